// File: rtl/mac_acumulador_if.sv
// Handshake and data bus of the multiply-accumulate stage.
// The master drives operands and start; the slave (the MAC) returns the sum and status.
interface mac_acumulador_if #(
  parameter int N = 25
);
  logic           start;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   Dato_A;
  logic [N-1:0]   Dato_B;
  logic [2*N-1:0] Datos_Sum;
  logic           sum_valid;
  logic           busy;
  logic           ovf;

  modport master (
    output start, in_valid, Dato_A, Dato_B,
    input  in_ready, Datos_Sum, sum_valid, busy, ovf
  );

  modport slave (
    input  start, in_valid, Dato_A, Dato_B,
    output in_ready, Datos_Sum, sum_valid, busy, ovf
  );
endinterface

// File: rtl/mac_acumulador.sv
// Signed fixed-point multiply-accumulate stage.
// Accumulates TAPS signed products at full 2N-bit width through a two-stage
// pipeline (product register, then accumulator) and flags two's-complement wrap.
module mac_acumulador #(
  parameter int N    = 25,
  parameter int TAPS = 5,
  parameter int CW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  mac_acumulador_if.slave  bus
);
  localparam int W = 2 * N;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic signed [W-1:0] r_prod;
  logic signed [W-1:0] r_acc;
  logic [CW-1:0]       r_cnt;
  logic                r_pend;
  logic                r_ovf;

  logic signed [N-1:0] w_a;
  logic signed [N-1:0] w_b;
  logic signed [W-1:0] w_prod;
  logic signed [W-1:0] w_sum;
  logic                w_add_ovf;
  logic                w_accept;
  logic                w_start_ok;
  logic                w_last;
  logic                w_in_ready;

  // Full-width signed product and accumulator adder with wrap detection.
  assign w_a       = bus.Dato_A;
  assign w_b       = bus.Dato_B;
  assign w_prod    = W'(w_a) * W'(w_b);
  assign w_sum     = r_acc + r_prod;
  assign w_add_ovf = (r_acc[W-1] == r_prod[W-1]) && (w_sum[W-1] != r_acc[W-1]);

  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_start_ok = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last     = (r_cnt == CW'(TAPS - 1));

  assign bus.Datos_Sum = r_acc;
  assign bus.ovf       = r_ovf;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and state-derived handshake/status outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_next        = r_state;
    w_in_ready    = 1'b0;
    bus.busy      = 1'b0;
    bus.sum_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_ACC;
      end
      S_ACC: begin
        w_in_ready = 1'b1;
        bus.busy   = 1'b1;
        if (bus.in_valid && w_last) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        bus.busy = 1'b1;
        w_next   = S_DONE;
      end
      S_DONE: begin
        bus.sum_valid = 1'b1;
        w_next        = bus.start ? S_ACC : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.in_ready = w_in_ready;

  // Datapath: capture product on accept, add the pending product one edge later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prod <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_pend <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_start_ok) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_pend <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (r_pend) begin
        r_acc <= w_sum;
        r_ovf <= r_ovf | w_add_ovf;
      end
      r_pend <= w_accept;
      if (w_accept) begin
        r_prod <= w_prod;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mac_acumulador.sv
// Scoreboard bench for mac_acumulador: the stimulus pushes the expected
// final sum/ovf computed with plain integer arithmetic; a monitor pops and
// compares on every sum_valid and checks the accept-to-valid latency.
module tb_mac_acumulador;
  localparam int N    = 25;
  localparam int TAPS = 5;
  localparam int CW   = 3;
  localparam int W    = 2 * N;

  localparam longint MAXV = (64'sd1 <<< (W - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (W - 1));
  localparam longint SPAN = 64'sd1 <<< W;

  typedef struct {
    logic [W-1:0] sum;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mac_acumulador_if #(.N(N)) bus ();

  mac_acumulador #(.N(N), .TAPS(TAPS), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   cyc = 0;
  int   last_acc_edge = -100;

  logic signed [N-1:0] va[TAPS];
  logic signed [N-1:0] vb[TAPS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: record accept edges, compare each presented sum against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.in_valid && bus.in_ready) last_acc_edge = cyc + 1;
    if (bus.sum_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sum_valid: got sum_valid=1 required 0 (no pending result)");
      end else begin
        e = exp_q.pop_front();
        check("sum", 64'(bus.Datos_Sum), 64'(e.sum));
        check("ovf", 64'(bus.ovf), 64'(e.ovf));
        check("latency", 64'(cyc - last_acc_edge), 64'd1);
      end
    end
  end

  // One full computation over va/vb. mode: 0 back-to-back, 1 toggle, 2 random gaps.
  // If start_now is set the caller is already inside the DONE cycle.
  task automatic compute(input int mode, input bit start_now);
    longint acc = 0;
    bit     ovf = 0;
    exp_t   e;
    bit     seen = 0;
    if (!start_now) @(posedge clk);
    if (!start_now) #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("cleared_sum", 64'(bus.Datos_Sum), 64'd0);
    check("cleared_ovf", 64'(bus.ovf), 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < TAPS; i++) begin
      if ((mode == 1 && i > 0) || (mode == 2 && $urandom_range(99) < 40)) begin
        bus.in_valid = 1'b0;
        bus.Dato_A   = N'($urandom);
        bus.Dato_B   = N'($urandom);
        @(negedge clk);
        if (mode == 1) check("in_ready_gap", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.Dato_A   = va[i];
      bus.Dato_B   = vb[i];
      acc += longint'(va[i]) * longint'(vb[i]);
      if (acc > MAXV) begin acc -= SPAN; ovf = 1; end
      else if (acc < MINV) begin acc += SPAN; ovf = 1; end
      @(negedge clk);
      if (mode == 1) check("in_ready", 64'(bus.in_ready), 64'd1);
      if (i == TAPS - 1) begin
        e.sum = W'(acc);
        e.ovf = ovf;
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    if (mode == 1) check("in_ready_after_last", 64'(bus.in_ready), 64'd0);
    for (int t = 0; t < 12 && !seen; t++) begin
      if (bus.sum_valid === 1'b1) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL sum_valid_timeout: got no sum_valid required one within 12 cycles");
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.Dato_A   = '0;
    bus.Dato_B   = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_sum",       64'(bus.Datos_Sum), 64'd0);
    check("rst_sum_valid", 64'(bus.sum_valid), 64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd0);
    check("rst_ovf",       64'(bus.ovf),       64'd0);

    // in_valid in IDLE is ignored: in_ready stays low.
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.Dato_A   = 25'sd16384;
    bus.Dato_B   = 25'sd16384;
    @(negedge clk);
    check("idle_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;

    // 1.0 * 1.0, five times: 5*2^28.
    for (int i = 0; i < TAPS; i++) begin va[i] = 25'sd16384; vb[i] = 25'sd16384; end
    compute(0, 0);
    check("direct_5x1p0", 64'(bus.Datos_Sum), 64'h5000_0000);

    // -1.0 * 1.0, five times: -5*2^28 in 50-bit two's complement.
    for (int i = 0; i < TAPS; i++) begin va[i] = -25'sd16384; vb[i] = 25'sd16384; end
    compute(0, 0);
    check("direct_neg", 64'(bus.Datos_Sum), 64'h3_FFFF_B000_0000);

    // Same as the first run with in_valid toggling.
    for (int i = 0; i < TAPS; i++) begin va[i] = 25'sd16384; vb[i] = 25'sd16384; end
    compute(1, 0);

    // Product 2^48: second add wraps, ovf sticky to the end.
    for (int i = 0; i < TAPS; i++) begin va[i] = -25'sd16777216; vb[i] = -25'sd16777216; end
    compute(0, 0);
    check("held_after_done", 64'(bus.ovf), 64'd1);

    // Randomized operands, random gaps, alternating start-in-DONE; also clears the ovf above.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < TAPS; i++) begin
        va[i] = N'($urandom);
        vb[i] = N'($urandom);
        if (r % 3 == 0) begin va[i] = -25'sd16777216; vb[i] = (i % 2 == 0) ? -25'sd16777216 : 25'sd16777215; end
      end
      compute(2, (r % 2 == 1));
    end

    // Abort: 3 pairs, ignored start alongside a 4th pair, then reset.
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.Dato_A   = 25'sd16384;
      bus.Dato_B   = 25'sd16384;
      @(posedge clk); #1;
    end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("start_ignored_busy", 64'(bus.busy), 64'd1);
    check("start_ignored_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy),      64'd0);
    check("abort_sum",  64'(bus.Datos_Sum), 64'd0);
    check("abort_ovf",  64'(bus.ovf),       64'd0);
    repeat (10) @(negedge clk);

    // Recovery after the abort.
    for (int i = 0; i < TAPS; i++) begin va[i] = 25'sd16384; vb[i] = -25'sd8192; end
    compute(0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
